// File: rtl/apb_m_if.sv
// APB requester: turns one valid/ready command into one SETUP+ACCESS transfer and
// reports completion on a single-cycle response strobe, aborting on a hung slave.
module apb_m_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and the requester may hold cmd_valid across
  // busy cycles with stable fields until it is taken.
  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = SETUP;
          cnt_d    = '0;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          if (!pwrite_q) rsp_rdata_d = prdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bus strobes are a registered decode of the next state.
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE) || rsp_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_m_if.sv
// Directed bench for apb_m_if with a small memory-backed APB slave and a
// response scoreboard keyed on expected data, error flag and arrival cycle.
module tb_apb_m_if;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pwrite, psel, penable, pready;
  logic [1:0]    dbg_state;

  apb_m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 pclk = ~pclk;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- APB slave model ----------------
  logic          hang = 1'b0;
  int            wait_n = 0;
  int            acc_cnt = 0;
  logic [DW-1:0] mem [16];
  logic          mem_vld [16] = '{default: 1'b0};

  assign pready = hang ? 1'b0 : (acc_cnt >= wait_n);
  assign prdata = mem_vld[paddr[3:0]] ? mem[paddr[3:0]] : (32'h1234_5677 + paddr);

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else if (!penable)              acc_cnt <= 0;
    if (psel && penable && pready && pwrite) begin
      mem[paddr[3:0]]     <= pwdata;
      mem_vld[paddr[3:0]] <= 1'b1;
    end
  end

  // ---------------- monitor (negedge) ----------------
  logic [DW-1:0] obs_data [64];
  logic          obs_err  [64];
  int            obs_cyc  [64];
  int            obs_wr = 0;
  int            psel_cnt = 0, pen_cnt = 0, rsp_cnt = 0;
  int            proto_err = 0, err_stray = 0, double_rsp = 0, stab_viol = 0;
  logic          prev_rsp = 1'b0;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_write;

  always @(negedge pclk) begin
    if (presetn) begin
      if (psel) psel_cnt++;
      if (penable) pen_cnt++;
      if (penable && !psel) proto_err++;
      if (rsp_err && !rsp_valid) err_stray++;
      if (rsp_valid && prev_rsp) double_rsp++;
      if (psel && !penable) begin
        lat_addr = paddr; lat_wdata = pwdata; lat_write = pwrite;
      end
      if (psel && penable && (paddr !== lat_addr || pwdata !== lat_wdata || pwrite !== lat_write))
        stab_viol++;
      if (rsp_valid) begin
        rsp_cnt++;
        obs_data[obs_wr % 64] = rsp_rdata;
        obs_err[obs_wr % 64]  = rsp_err;
        obs_cyc[obs_wr % 64]  = cyc;
        obs_wr++;
      end
      prev_rsp = rsp_valid;
    end else begin
      prev_rsp = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];
  int            exp_cyc_q[$];
  int            obs_rd = 0;
  logic [DW-1:0] ref_mem [16];
  logic          ref_vld [16] = '{default: 1'b0};
  logic [DW-1:0] model_rdata = '0;
  int            n_tests = 0, n_fail = 0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_vld[a[3:0]] ? ref_mem[a[3:0]] : (32'h1234_5677 + a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  // Drive one command; waits (bounded) for cmd_ready, pushes the expected
  // response and returns one cycle after the accept edge.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic err, input int waits, input logic hold);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 40) begin step(); n++; end
    check("cmd_ready_for_accept", 64'(cmd_ready), 64'd1);
    if (err) begin
      model_rdata = '0;
    end else if (w) begin
      ref_mem[a[3:0]] = d;
      ref_vld[a[3:0]] = 1'b1;
    end else begin
      model_rdata = ref_rd(a);
    end
    exp_q.push_back({err, model_rdata});
    exp_cyc_q.push_back(cyc + 3 + waits);
    step();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, output int got_cyc);
    int n = 0;
    logic [DW:0] e;
    int ec;
    got_cyc = -1;
    while (obs_wr == obs_rd && n < 100) begin step(); n++; end
    e  = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    check({tag, "_rsp_arrived"}, 64'(obs_wr != obs_rd), 64'd1);
    if (obs_wr != obs_rd) begin
      check({tag, "_rdata"}, 64'(obs_data[obs_rd % 64]), 64'(e[DW-1:0]));
      check({tag, "_err"},   64'(obs_err[obs_rd % 64]),  64'(e[DW]));
      check({tag, "_cycle"}, 64'(obs_cyc[obs_rd % 64]),  64'(ec));
      got_cyc = obs_cyc[obs_rd % 64];
      obs_rd++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps0, pe0, rc0, c0, c1, c2, c3, n;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) step();

    // Reset values
    check("rst_psel",      64'(psel),      64'd0);
    check("rst_penable",   64'(penable),   64'd0);
    check("rst_pwrite",    64'(pwrite),    64'd0);
    check("rst_paddr",     64'(paddr),     64'd0);
    check("rst_pwdata",    64'(pwdata),    64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_state",     64'(dbg_state), 64'd0);
    presetn = 1'b1;
    step();
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: zero-wait write
    ps0 = psel_cnt; pe0 = pen_cnt;
    send(1'b1, 32'd2, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    check("t1_setup_psel",    64'(psel),      64'd1);
    check("t1_setup_penable", 64'(penable),   64'd0);
    check("t1_pwrite",        64'(pwrite),    64'd1);
    check("t1_paddr",         64'(paddr),     64'd2);
    check("t1_pwdata",        64'(pwdata),    64'hDEAD_BEEF);
    check("t1_busy",          64'(busy),      64'd1);
    check("t1_cmd_ready_low", 64'(cmd_ready), 64'd0);
    step();
    check("t1_access_penable", 64'(penable), 64'd1);
    get_rsp("t1", c0);
    check("t1_busy_in_rsp", 64'(busy), 64'd1);
    check("t1_psel_cycles", 64'(psel_cnt - ps0), 64'd2);
    check("t1_pen_cycles",  64'(pen_cnt - pe0),  64'd1);
    step();
    check("t1_busy_after", 64'(busy), 64'd0);

    // 2: read, slave ready already during SETUP
    pe0 = pen_cnt;
    send(1'b0, 32'd1, '0, 1'b0, 0, 1'b0);
    get_rsp("t2", c0);
    check("t2_pen_cycles", 64'(pen_cnt - pe0), 64'd1);

    // 3: read with three wait states
    wait_n = 3; pe0 = pen_cnt;
    send(1'b0, 32'd5, '0, 1'b0, 3, 1'b0);
    get_rsp("t3", c0);
    check("t3_pen_cycles", 64'(pen_cnt - pe0), 64'd4);
    wait_n = 0;

    // 4: hung slave -> timeout abort after 16 ACCESS cycles
    hang = 1'b1; ps0 = psel_cnt; pe0 = pen_cnt;
    send(1'b0, 32'd7, '0, 1'b1, 15, 1'b0);
    get_rsp("t4", c0);
    check("t4_psel_cycles", 64'(psel_cnt - ps0), 64'd17);
    check("t4_pen_cycles",  64'(pen_cnt - pe0),  64'd16);
    check("t4_psel_dropped", 64'(psel), 64'd0);
    check("t4_cmd_ready",   64'(cmd_ready), 64'd1);
    hang = 1'b0;

    // 5: back-to-back W0,R0,W3,R3 with cmd_valid held
    send(1'b1, 32'd0, 32'hA5A5_0001, 1'b0, 0, 1'b1);
    send(1'b0, 32'd0, '0,            1'b0, 0, 1'b1);
    send(1'b1, 32'd3, 32'h5A5A_0303, 1'b0, 0, 1'b1);
    send(1'b0, 32'd3, '0,            1'b0, 0, 1'b0);
    get_rsp("t5_w0", c0);
    get_rsp("t5_r0", c1);
    get_rsp("t5_w3", c2);
    get_rsp("t5_r3", c3);
    check("t5_gap01", 64'(c1 - c0), 64'd3);
    check("t5_gap12", 64'(c2 - c1), 64'd3);
    check("t5_gap23", 64'(c3 - c2), 64'd3);

    // 6: asynchronous reset during ACCESS
    hang = 1'b1;
    send(1'b0, 32'd6, '0, 1'b0, 0, 1'b0);
    n = 0;
    while (!penable && n < 10) begin step(); n++; end
    check("t6_in_access", 64'(penable), 64'd1);
    rc0 = rsp_cnt;
    #2 presetn = 1'b0;
    #1;
    check("t6_psel_async",    64'(psel),      64'd0);
    check("t6_penable_async", 64'(penable),   64'd0);
    check("t6_state_async",   64'(dbg_state), 64'd0);
    exp_q.delete(); exp_cyc_q.delete();
    model_rdata = '0;
    hang = 1'b0;
    repeat (2) step();
    presetn = 1'b1;
    repeat (6) step();
    check("t6_no_rsp",    64'(rsp_cnt - rc0), 64'd0);
    check("t6_cmd_ready", 64'(cmd_ready),     64'd1);
    check("t6_busy",      64'(busy),          64'd0);
    send(1'b1, 32'd9, 32'hC0FF_EE11, 1'b0, 0, 1'b0);
    get_rsp("t6_w9", c0);
    send(1'b0, 32'd9, '0, 1'b0, 0, 1'b0);
    get_rsp("t6_r9", c0);

    // Global protocol observations
    repeat (3) step();
    check("penable_without_psel", 64'(proto_err),  64'd0);
    check("rsp_err_without_valid", 64'(err_stray), 64'd0);
    check("rsp_valid_multi_cycle", 64'(double_rsp), 64'd0);
    check("addr_data_stability",  64'(stab_viol),  64'd0);
    check("unmatched_responses",  64'(obs_wr - obs_rd), 64'd0);
    check("pending_expected",     64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
